// File: rtl/channel_sequencer_if.sv
// channel_sequencer_if: control, ADC handshake and distributor bus of the
// telemetry channel sequencer. master = sequencer side, slave = environment.
interface channel_sequencer_if;
  // run control
  logic        enable;
  logic [31:0] skipMask;
  logic        clrErr;
  // ADC handshake
  logic        adcStart;
  logic [4:0]  adcChannel;
  logic [11:0] adcData;
  logic        adcDone;
  // distributor bus and status
  logic [11:0] data;
  logic        valid;
  logic [4:0]  address;
  logic        frameStart;
  logic [15:0] frameCount;
  logic        timeoutErr;

  modport master (
    input  enable, skipMask, clrErr, adcData, adcDone,
    output adcStart, adcChannel, data, valid, address,
           frameStart, frameCount, timeoutErr
  );

  modport slave (
    output enable, skipMask, clrErr, adcData, adcDone,
    input  adcStart, adcChannel, data, valid, address,
           frameStart, frameCount, timeoutErr
  );
endinterface

// File: rtl/channel_sequencer.sv
// channel_sequencer: walks channels 0..NUM_CHANNELS-1, starts one ADC
// conversion per unmasked channel and presents each result with a fixed
// valid-high window followed by a valid-low gap. Also marks frame starts,
// counts completed frames and raises a sticky ADC timeout flag.
module channel_sequencer #(
  parameter int NUM_CHANNELS = 18,
  parameter int VALID_HOLD   = 4,
  parameter int GAP          = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  channel_sequencer_if.master io_bus
);

  typedef enum logic [2:0] {IDLE, SELECT, CONVERT, PRESENT, GAPW} state_t;

  localparam logic [4:0]  LAST_CH   = 5'(NUM_CHANNELS - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(VALID_HOLD - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

  state_t      r_state;
  logic [4:0]  r_ch;
  logic [15:0] r_timer;
  logic        r_adcStart;
  logic [4:0]  r_adcChannel;
  logic [11:0] r_data;
  logic        r_valid;
  logic [4:0]  r_address;
  logic        r_frameStart;
  logic [15:0] r_frameCount;
  logic        r_timeoutErr;

  logic        w_ch_last;
  logic [4:0]  w_ch_next;
  logic        w_masked;
  logic        w_to_expire;

  assign w_ch_last   = (r_ch == LAST_CH);
  assign w_ch_next   = w_ch_last ? 5'd0 : r_ch + 5'd1;
  assign w_masked    = io_bus.skipMask[r_ch];
  // Timeout fires only when adcDone is absent on the last allowed cycle,
  // so a completion arriving exactly then still delivers real data.
  assign w_to_expire = (r_state == CONVERT) && !io_bus.adcDone && (r_timer == TO_LAST);

  // Sequencer FSM with registered outputs; one timer serves conversion,
  // valid-hold and gap counting since those phases never overlap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ch         <= 5'd0;
      r_timer      <= 16'd0;
      r_adcStart   <= 1'b0;
      r_adcChannel <= 5'd0;
      r_data       <= 12'd0;
      r_valid      <= 1'b0;
      r_address    <= 5'd0;
      r_frameStart <= 1'b0;
      r_frameCount <= 16'd0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_adcStart   <= 1'b0;
      r_frameStart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.enable) begin
            r_state      <= SELECT;
            r_ch         <= 5'd0;
            r_frameStart <= 1'b1;
          end
        end
        SELECT: begin
          if (w_masked) begin
            r_ch <= w_ch_next;
            if (w_ch_last) begin
              r_frameCount <= r_frameCount + 16'd1;
              r_frameStart <= 1'b1;
            end
          end else begin
            r_adcStart   <= 1'b1;
            r_adcChannel <= r_ch;
            r_timer      <= 16'd0;
            r_state      <= CONVERT;
          end
        end
        CONVERT: begin
          if (io_bus.adcDone) begin
            r_data    <= io_bus.adcData;
            r_address <= r_ch;
            r_valid   <= 1'b1;
            r_timer   <= 16'd0;
            r_state   <= PRESENT;
          end else if (w_to_expire) begin
            r_data    <= 12'hFFF;
            r_address <= r_ch;
            r_valid   <= 1'b1;
            r_timer   <= 16'd0;
            r_state   <= PRESENT;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        PRESENT: begin
          if (r_timer == HOLD_LAST) begin
            r_valid <= 1'b0;
            r_timer <= 16'd0;
            r_state <= GAPW;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        GAPW: begin
          if (r_timer == GAP_LAST) begin
            r_timer <= 16'd0;
            if (w_ch_last) r_frameCount <= r_frameCount + 16'd1;
            if (!io_bus.enable) begin
              // a partial frame is abandoned; the next run restarts at 0
              r_ch    <= 5'd0;
              r_state <= IDLE;
            end else begin
              r_ch         <= w_ch_next;
              r_frameStart <= w_ch_last;
              r_state      <= SELECT;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // a new timeout outranks a simultaneous clear
      if (w_to_expire)        r_timeoutErr <= 1'b1;
      else if (io_bus.clrErr) r_timeoutErr <= 1'b0;
    end
  end

  assign io_bus.adcStart   = r_adcStart;
  assign io_bus.adcChannel = r_adcChannel;
  assign io_bus.data       = r_data;
  assign io_bus.valid      = r_valid;
  assign io_bus.address    = r_address;
  assign io_bus.frameStart = r_frameStart;
  assign io_bus.frameCount = r_frameCount;
  assign io_bus.timeoutErr = r_timeoutErr;

endmodule
